// File: rtl/l_next_arb_pkg.sv
// Shared types and constants for the L_NEXT arbiter.
//   state_e    : transaction FSM encoding (idle, request, transfer, done)
//   src_e      : requester code (I-cache / D-cache)
//   line_off_w : byte-offset width of one cache line for a given geometry
package l_next_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StXfer = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic {
    SrcI = 1'b0,
    SrcD = 1'b1
  } src_e;

  function automatic int unsigned line_off_w(input int unsigned beats,
                                             input int unsigned data_w);
    return $clog2(beats * data_w / 8);
  endfunction

  // Offset width for the default geometry: 16 beats of 32 bits = 64 B lines.
  localparam int unsigned LINE_OFF_W = line_off_w(16, 32);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (I-cache vs D-cache).
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (last grant returns to I)
//   en_i     : grant enable; the last-grant memory only advances when set
//   i_req_i  : I-cache request
//   d_req_i  : D-cache request
//   valid_o  : at least one request pending
//   gnt_o    : winning source (combinational)
module rr_arb2
  import l_next_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic valid_o,
  output src_e gnt_o
);

  src_e last_q;

  always_comb begin
    valid_o = i_req_i | d_req_i;
    if (i_req_i && d_req_i) begin
      // Tie: the source that did not win last time goes first.
      gnt_o = (last_q == SrcI) ? SrcD : SrcI;
    end else if (d_req_i) begin
      gnt_o = SrcD;
    end else begin
      gnt_o = SrcI;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= SrcI;
    end else if (en_i && valid_o) begin
      last_q <= gnt_o;
    end
  end

endmodule

// File: rtl/l_next_arb.sv
// Arbiter between I-cache and D-cache line misses and the next memory level.
// One line transaction at a time: grant, address request, burst, done pulse.
//   clk, rst                 : clock, synchronous active-high reset
//   i_req/i_add_in           : I-cache line read request and address
//   i_rvalid/i_done          : I-cache read beat valid, completion pulse
//   d_req/d_we/d_add_in      : D-cache request, write-back flag, address
//   d_wdata/d_wready         : D-cache write-back beat and its consume strobe
//   d_rvalid/d_done          : D-cache read beat valid, completion pulse
//   up_rdata                 : registered read beat shared by both caches
//   nl_req/nl_we/nl_add      : request, write flag, line-aligned address
//   nl_ack                   : next level accepted the request
//   nl_rdata/nl_rvalid       : read beat from the next level
//   nl_wdata/nl_wvalid/nl_wready : write beat towards the next level
module l_next_arb
  import l_next_pkg::*;
#(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEATS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_add_in,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_add_in,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wready,
  output logic              d_rvalid,
  output logic              d_done,
  output logic [DATA_W-1:0] up_rdata,
  output logic              nl_req,
  output logic              nl_we,
  output logic [ADDR_W-1:0] nl_add,
  input  logic              nl_ack,
  input  logic [DATA_W-1:0] nl_rdata,
  input  logic              nl_rvalid,
  output logic [DATA_W-1:0] nl_wdata,
  output logic              nl_wvalid,
  input  logic              nl_wready
);

  localparam int unsigned LineOffW = line_off_w(BEATS, DATA_W);
  localparam int unsigned CntW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e            state_q;
  src_e              src_q;
  logic [CntW-1:0]   count_q;
  logic              last_beat;
  logic              arb_en;
  logic              arb_valid;
  src_e              arb_gnt;
  logic [ADDR_W-1:0] add_sel;
  logic [ADDR_W-1:0] add_aligned;

  assign arb_en = (state_q == StIdle);

  rr_arb2 u_rr_arb2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (arb_en),
    .i_req_i (i_req),
    .d_req_i (d_req),
    .valid_o (arb_valid),
    .gnt_o   (arb_gnt)
  );

  assign add_sel     = (arb_gnt == SrcD) ? d_add_in : i_add_in;
  assign add_aligned = {add_sel[ADDR_W-1:LineOffW], {LineOffW{1'b0}}};
  assign last_beat   = (count_q == CntW'(BEATS - 1));

  // Write beats pass straight through; nl_wvalid is only high in a write XFER.
  assign nl_wdata = d_wdata;
  assign d_wready = nl_wvalid & nl_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= SrcI;
      count_q   <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      up_rdata  <= '0;
      nl_req    <= 1'b0;
      nl_we     <= 1'b0;
      nl_add    <= '0;
      nl_wvalid <= 1'b0;
    end else begin
      // Beat-valid and done strobes are single-cycle pulses.
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            src_q   <= arb_gnt;
            nl_we   <= (arb_gnt == SrcD) && d_we;
            nl_add  <= add_aligned;
            nl_req  <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (nl_ack) begin
            nl_req    <= 1'b0;
            count_q   <= '0;
            nl_wvalid <= nl_we;
            state_q   <= StXfer;
          end
        end
        StXfer: begin
          if (nl_we) begin
            if (nl_wvalid && nl_wready) begin
              count_q <= count_q + CntW'(1);
              if (last_beat) begin
                nl_wvalid <= 1'b0;
                d_done    <= 1'b1;
                state_q   <= StDone;
              end
            end
          end else if (nl_rvalid) begin
            up_rdata <= nl_rdata;
            count_q  <= count_q + CntW'(1);
            if (src_q == SrcD) d_rvalid <= 1'b1;
            else               i_rvalid <= 1'b1;
            if (last_beat) begin
              // Done lands in the same cycle as the final rvalid.
              if (src_q == SrcD) d_done <= 1'b1;
              else               i_done <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l_next_arb.sv
module tb_l_next_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [25:0] i_add_in, d_add_in;
  logic [31:0] d_wdata, nl_rdata;
  logic        nl_ack, nl_rvalid, nl_wready;
  logic        i_rvalid, i_done, d_wready, d_rvalid, d_done;
  logic [31:0] up_rdata, nl_wdata;
  logic        nl_req, nl_we, nl_wvalid;
  logic [25:0] nl_add;

  int checks   = 0;
  int failures = 0;
  bit last_d   = 1'b0;  // reference model: last grant went to D

  always #5 clk = ~clk;

  l_next_arb #(.ADDR_W(26), .DATA_W(32), .BEATS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_add_in  (i_add_in),
    .i_rvalid  (i_rvalid),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_add_in  (d_add_in),
    .d_wdata   (d_wdata),
    .d_wready  (d_wready),
    .d_rvalid  (d_rvalid),
    .d_done    (d_done),
    .up_rdata  (up_rdata),
    .nl_req    (nl_req),
    .nl_we     (nl_we),
    .nl_add    (nl_add),
    .nl_ack    (nl_ack),
    .nl_rdata  (nl_rdata),
    .nl_rvalid (nl_rvalid),
    .nl_wdata  (nl_wdata),
    .nl_wvalid (nl_wvalid),
    .nl_wready (nl_wready)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_add_in = '0; d_add_in = '0; d_wdata = '0;
    nl_ack = 0; nl_rvalid = 0; nl_rdata = '0; nl_wready = 0;
    tick();
    tick();
    rst = 1'b0;
    last_d = 1'b0;
  endtask

  // Acts as the next level for one transaction and checks what the requester sees.
  // mode 1: back-to-back read beats with data 0..15, or nl_wready toggling each cycle.
  task automatic serve(input bit src_d, input bit we, input logic [25:0] addr,
                       input int ack_delay, input int ack_hold, input int mode);
    logic [25:0] exp_add;
    logic [31:0] q[$];
    logic [31:0] exp_beat;
    int t, sent, got, hs, cyc, ack_left;
    bit done_seen, up_v, oth_v, oth_d, own_d, r, tog;
    exp_add = addr & ~26'h3F;
    t = 0;
    while (nl_req !== 1'b1 && t < 20) begin
      check("early_done", {i_done, d_done}, 0);
      tick();
      t++;
    end
    check("req_seen", nl_req, 1);
    if (nl_req !== 1'b1) return;
    check("nl_add", nl_add, exp_add);
    check("nl_we", nl_we, we);
    for (int k = 0; k < ack_delay; k++) begin
      tick();
      check("req_hold", nl_req, 1);
      check("add_hold", nl_add, exp_add);
    end
    nl_ack = 1'b1;
    tick();
    check("req_drop", nl_req, 0);
    ack_left = ack_hold - 1;
    sent = 0; got = 0; hs = 0; cyc = 0; done_seen = 0; tog = 0;
    while (!done_seen && cyc < 300) begin
      if (ack_left > 0) ack_left--;
      else nl_ack = 1'b0;
      if (!we) begin
        if (sent < 16) nl_rvalid = (mode == 1) || ($urandom_range(0, 3) != 0);
        else nl_rvalid = $urandom_range(0, 1) == 1;  // stray beats must be ignored
        nl_rdata = (mode == 1) ? 32'(sent) : $urandom;
        if (sent < 16 && nl_rvalid) begin
          q.push_back(nl_rdata);
          sent++;
        end
        tick();
      end else begin
        tog = ~tog;
        r = (mode == 1) ? tog : ($urandom_range(0, 1) == 1);
        nl_wready = r;
        d_wdata = $urandom;
        #1;
        check("nl_wvalid", nl_wvalid, 1);
        check("d_wready", d_wready, r);
        check("nl_wdata", nl_wdata, d_wdata);
        if (r) hs++;
        tick();
      end
      cyc++;
      up_v  = src_d ? d_rvalid : i_rvalid;
      oth_v = src_d ? i_rvalid : d_rvalid;
      oth_d = src_d ? i_done : d_done;
      own_d = src_d ? d_done : i_done;
      check("other_rvalid", oth_v, 0);
      check("other_done", oth_d, 0);
      check("no_req_in_xfer", nl_req, 0);
      if (we) check("wr_no_rvalid", up_v, 0);
      if (up_v && !we) begin
        exp_beat = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        check("rdata", up_rdata, exp_beat);
        got++;
      end
      if (own_d) begin
        done_seen = 1'b1;
        if (we) check("wr_beats", hs, 16);
        else check("done_with_16th", {up_v, 8'(got)}, {1'b1, 8'd16});
      end
    end
    check("done_seen", done_seen, 1);
    if (src_d) d_req = 1'b0;
    else i_req = 1'b0;
    nl_ack = 0; nl_rvalid = 0; nl_wready = 0;
    tick();
    check("done_pulse", {i_done, d_done}, 0);
    last_d = src_d;
  endtask

  initial begin
    bit pi, pd, wd, win_d;
    logic [25:0] ai, ad;
    int r;

    // Reset state
    do_reset();
    check("rst_nl_req", nl_req, 0);
    check("rst_nl_we", nl_we, 0);
    check("rst_nl_add", nl_add, 0);
    check("rst_up_rdata", up_rdata, 0);
    check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    check("rst_done", {i_done, d_done}, 0);
    check("rst_wvalid", {nl_wvalid, d_wready}, 0);

    // Directed I-cache line fill, data 0..15
    i_req = 1; i_add_in = 26'h012345F;
    serve(1'b0, 1'b0, 26'h012345F, 1, 1, 1);
    check("t1_nl_add_val", 26'h012345F & ~26'h3F, 26'h0123440);

    // Simultaneous requests twice after reset: D, I, D, I
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      i_req = 1; d_req = 1; d_we = 0;
      i_add_in = 26'(rep * 64 + 26'h100); d_add_in = 26'(rep * 64 + 26'h200);
      serve(1'b1, 1'b0, d_add_in, 0, 1, 0);
      serve(1'b0, 1'b0, i_add_in, 0, 1, 0);
    end

    // D-cache write-back with nl_wready toggling
    d_req = 1; d_we = 1; d_add_in = 26'h3FFFFFF;
    serve(1'b1, 1'b1, 26'h3FFFFFF, 2, 1, 1);
    d_we = 0;

    // Reset after 5 of 16 read beats
    i_req = 1; i_add_in = 26'h0ABCDE7;
    tick();
    check("t4_req", nl_req, 1);
    nl_ack = 1;
    tick();
    nl_ack = 0;
    for (int k = 0; k < 5; k++) begin
      nl_rvalid = 1; nl_rdata = $urandom;
      tick();
      check("t4_beat", i_rvalid, 1);
    end
    nl_rvalid = 0; rst = 1;
    tick();
    rst = 0;
    last_d = 1'b0;
    check("t4_nl_req", nl_req, 0);
    check("t4_no_done", {i_done, d_done, i_rvalid}, 0);
    serve(1'b0, 1'b0, 26'h0ABCDE7, 1, 1, 0);

    // Stray nl_ack/nl_rvalid in IDLE, ack held 3 cycles in REQ/XFER
    nl_ack = 1; nl_rvalid = 1; nl_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_idle", {i_rvalid, d_rvalid, nl_req}, 0);
    end
    nl_ack = 0; nl_rvalid = 0;
    i_req = 1; i_add_in = 26'h0000040;
    serve(1'b0, 1'b0, 26'h0000040, 0, 3, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_no_extra_req", nl_req, 0);
    end

    // Randomized request mix against the round-robin model
    pi = 0; pd = 0; wd = 0; ai = '0; ad = '0;
    for (int n = 0; n < 24; n++) begin
      if (!pi && !pd) begin
        r = $urandom_range(1, 3);
        pi = r[0]; pd = r[1];
        ai = 26'($urandom); ad = 26'($urandom); wd = $urandom_range(0, 1) == 1;
      end
      i_req = pi; d_req = pd; i_add_in = ai; d_add_in = ad; d_we = wd;
      win_d = pd && (!pi || !last_d);
      serve(win_d, win_d && wd, win_d ? ad : ai, $urandom_range(0, 3), 1, 0);
      if (win_d) pd = 0;
      else pi = 0;
      if ($urandom_range(0, 1) == 1) begin
        if (win_d) begin
          pd = 1; ad = 26'($urandom); wd = $urandom_range(0, 1) == 1;
        end else begin
          pi = 1; ai = 26'($urandom);
        end
      end
    end
    i_req = 0; d_req = 0;
    tick();
    tick();
    check("end_idle", nl_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
